// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - state encoding and default geometry for the word-RAM controller
package ram_ctrl_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_AW    = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    INIT = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/ram_ctrl_if.sv
// rtl/ram_ctrl_if.sv - requester handshake plus bank-side strobes of the word-RAM controller
interface ram_ctrl_if
  import ram_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
);

  logic             req;
  logic             we;
  logic             verify;
  logic             init;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wdata;
  logic             ack;
  logic             busy;
  logic [WIDTH-1:0] rdata;
  logic             err;
  logic [DEPTH-1:0] mem_sel;
  logic             mem_rw;
  logic [WIDTH-1:0] mem_din;
  logic [WIDTH-1:0] mem_dout;

  // master = requester plus bank; slave = the controller
  modport master (
    output req, we, verify, init, addr, wdata, mem_dout,
    input  ack, busy, rdata, err, mem_sel, mem_rw, mem_din
  );

  modport slave (
    input  req, we, verify, init, addr, wdata, mem_dout,
    output ack, busy, rdata, err, mem_sel, mem_rw, mem_din
  );

endinterface

// File: rtl/addr_dec.sv
// rtl/addr_dec.sv - one-hot word select decoder with enable
module addr_dec #(
  parameter int AW    = 2,
  parameter int DEPTH = 4
) (
  input  logic             en,
  input  logic [AW-1:0]    addr,
  output logic [DEPTH-1:0] sel
);

  always_comb begin
    sel = '0;
    if (en) sel[addr] = 1'b1;
  end

endmodule

// File: rtl/ram_ctrl.sv
// rtl/ram_ctrl.sv - request/ack sequencer for the word-RAM bank: write, read, verify-write, initialise
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic       clk,
  input  logic       clear,
  ram_ctrl_if.slave  bus
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             verify_q;
  logic             we_q;

  logic [AW-1:0]    dec_addr;
  logic             dec_en;
  logic [DEPTH-1:0] dec_sel;

  // Decode the select for the state being entered so mem_sel is a plain register.
  always_comb begin
    dec_addr = addr_q;
    dec_en   = 1'b0;
    case (state)
      IDLE: begin
        dec_addr = bus.init ? '0 : bus.addr;
        dec_en   = bus.init | bus.req;
      end
      WR:      dec_en = we_q & verify_q;
      RD:      dec_en = 1'b1;
      INIT: begin
        dec_addr = cnt + AW'(1);
        dec_en   = (cnt != LAST);
      end
      default: dec_en = 1'b0;
    endcase
  end

  addr_dec #(.AW(AW), .DEPTH(DEPTH)) u_dec (
    .en   (dec_en),
    .addr (dec_addr),
    .sel  (dec_sel)
  );

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      verify_q    <= 1'b0;
      we_q        <= 1'b0;
      bus.ack     <= 1'b0;
      bus.busy    <= 1'b0;
      bus.err     <= 1'b0;
      bus.rdata   <= '0;
      bus.mem_sel <= '0;
      bus.mem_rw  <= 1'b0;
      bus.mem_din <= '0;
    end else begin
      bus.mem_sel <= dec_sel;
      bus.ack     <= 1'b0;
      bus.mem_rw  <= 1'b0;
      bus.mem_din <= '0;
      case (state)
        IDLE: begin
          if (bus.init || bus.req) begin
            addr_q   <= bus.addr;
            wdata_q  <= bus.wdata;
            verify_q <= bus.verify & bus.we;
            we_q     <= bus.we;
            bus.err  <= 1'b0;
            bus.busy <= 1'b1;
          end
          if (bus.init) begin
            state      <= INIT;
            cnt        <= '0;
            bus.mem_rw <= 1'b1;
          end else if (bus.req) begin
            state       <= bus.we ? WR : RD;
            bus.mem_rw  <= bus.we;
            bus.mem_din <= bus.we ? bus.wdata : '0;
          end
        end
        WR: begin
          if (we_q && verify_q) begin
            state <= RD;
          end else begin
            state   <= DONE;
            bus.ack <= 1'b1;
          end
        end
        RD: state <= CAP;
        CAP: begin
          bus.rdata <= bus.mem_dout;
          if (verify_q) bus.err <= (bus.mem_dout != wdata_q);
          state   <= DONE;
          bus.ack <= 1'b1;
        end
        INIT: begin
          cnt <= cnt + AW'(1);
          if (cnt == LAST) begin
            state   <= DONE;
            bus.ack <= 1'b1;
          end else begin
            bus.mem_rw <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// tb/tb_ram_ctrl.sv - self-checking bench for ram_ctrl with a bank model and cycle timeline model
module tb_ram_ctrl;
  import ram_ctrl_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int K_WR = 0, K_RD = 1, K_VF = 2, K_IN = 3;

  logic clk = 1'b0;
  logic clear = 1'b1;
  always #5 clk = ~clk;

  ram_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) bus ();

  ram_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  // bank: gated write while mem_rw, unselected words read as zero
  logic [WIDTH-1:0] bank [DEPTH];
  bit stuck = 1'b0;
  always @(posedge clk)
    if (bus.mem_rw)
      for (int i = 0; i < DEPTH; i++)
        if (bus.mem_sel[i]) bank[i] <= bus.mem_din;

  always_comb begin
    bus.mem_dout = '0;
    for (int i = 0; i < DEPTH; i++)
      if (bus.mem_sel[i]) bus.mem_dout = bus.mem_dout | bank[i];
    if (stuck) bus.mem_dout[0] = 1'b0;
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit               ack;
    bit               busy;
    logic [DEPTH-1:0] sel;
    bit               rw;
    logic [WIDTH-1:0] din;
    bit               set_rd;
    logic [WIDTH-1:0] rd;
    bit               set_err;
    bit               err;
  } exp_t;

  exp_t exp_q[$];
  logic [WIDTH-1:0] held_rd = '0;
  bit held_err = 1'b0;
  bit run_cmp = 1'b0;
  logic [WIDTH-1:0] mdl [DEPTH];

  function automatic exp_t mk(bit a, bit b, logic [DEPTH-1:0] s, bit r, logic [WIDTH-1:0] d);
    exp_t e;
    e.ack = a; e.busy = b; e.sel = s; e.rw = r; e.din = d;
    e.set_rd = 1'b0; e.rd = '0; e.set_err = 1'b0; e.err = 1'b0;
    return e;
  endfunction

  function automatic logic [DEPTH-1:0] oh(int a);
    logic [DEPTH-1:0] r;
    r = '0;
    r[a] = 1'b1;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] seen(logic [WIDTH-1:0] v);
    return stuck ? (v & ~WIDTH'(1)) : v;
  endfunction

  // expected outputs for cycles 1..N after an accept edge, taken from the command timelines
  task automatic schedule(int kind, int a, logic [WIDTH-1:0] wd);
    exp_t e;
    case (kind)
      K_WR: begin
        e = mk(0, 1, oh(a), 1, wd); e.set_err = 1; exp_q.push_back(e);
        exp_q.push_back(mk(1, 1, '0, 0, '0));
        mdl[a] = wd;
      end
      K_RD: begin
        e = mk(0, 1, oh(a), 0, '0); e.set_err = 1; exp_q.push_back(e);
        exp_q.push_back(mk(0, 1, oh(a), 0, '0));
        e = mk(1, 1, '0, 0, '0); e.set_rd = 1; e.rd = seen(mdl[a]); exp_q.push_back(e);
      end
      K_VF: begin
        e = mk(0, 1, oh(a), 1, wd); e.set_err = 1; exp_q.push_back(e);
        exp_q.push_back(mk(0, 1, oh(a), 0, '0));
        exp_q.push_back(mk(0, 1, oh(a), 0, '0));
        mdl[a] = wd;
        e = mk(1, 1, '0, 0, '0); e.set_rd = 1; e.rd = seen(wd);
        e.set_err = 1; e.err = (seen(wd) != wd); exp_q.push_back(e);
      end
      default: begin
        for (int i = 0; i < DEPTH; i++) begin
          e = mk(0, 1, oh(i), 1, '0); e.set_err = (i == 0); exp_q.push_back(e);
          mdl[i] = '0;
        end
        exp_q.push_back(mk(1, 1, '0, 0, '0));
      end
    endcase
  endtask

  initial begin : compare
    exp_t e;
    forever begin
      @(negedge clk);
      if (run_cmp) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = mk(0, 0, '0, 0, '0);
        if (e.set_rd) held_rd = e.rd;
        if (e.set_err) held_err = e.err;
        chk("cyc_ack", bus.ack, e.ack);
        chk("cyc_busy", bus.busy, e.busy);
        chk("cyc_sel", bus.mem_sel, e.sel);
        chk("cyc_rw", bus.mem_rw, e.rw);
        chk("cyc_din", bus.mem_din, e.din);
        chk("cyc_rdata", bus.rdata, held_rd);
        chk("cyc_err", bus.err, held_err);
      end
    end
  end

  int lat;
  logic [DEPTH-1:0] sel_log [21];
  bit rw_log [21];

  task automatic wait_ack();
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) bus.init = 1'b0;
      sel_log[k] = bus.mem_sel;
      rw_log[k]  = bus.mem_rw;
      if (bus.ack) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      checks++; fails++;
      $display("FAIL ack_timeout: got no ack within 20 cycles at %0t", $time);
    end
  endtask

  task automatic cmd(int kind, int a, logic [WIDTH-1:0] wd);
    @(negedge clk);
    bus.init   = (kind == K_IN);
    bus.req    = (kind != K_IN);
    bus.we     = (kind == K_WR || kind == K_VF);
    bus.verify = (kind == K_VF);
    bus.addr   = AW'(a);
    bus.wdata  = wd;
    @(posedge clk);
    schedule(kind, a, wd);
    wait_ack();
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  logic [DEPTH-1:0] walk [4];

  initial begin
    walk = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    bus.req = 0; bus.we = 0; bus.verify = 0; bus.init = 0; bus.addr = '0; bus.wdata = '0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    #1 clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_sel", bus.mem_sel, 0);
    chk("rst_rw", bus.mem_rw, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_err", bus.err, 0);
    clear = 1'b1;
    run_cmp = 1'b1;

    cmd(K_WR, 2, 16'h002D);
    chk("wr_lat", lat, 2);
    chk("wr_sel_c1", sel_log[1], 4'b0100);
    chk("wr_rw_c1", rw_log[1], 1);
    chk("wr_rw_c2", rw_log[2], 0);
    cmd(K_RD, 2, '0);
    chk("rd_lat", lat, 3);
    chk("rd_data", bus.rdata, 16'h002D);

    cmd(K_VF, 1, 16'h07FF);
    chk("vf_lat", lat, 4);
    chk("vf_err_ok", bus.err, 0);
    stuck = 1'b1;
    cmd(K_VF, 3, 16'h0F0F);
    chk("vf_err_bad", bus.err, 1);
    chk("vf_rd_bad", bus.rdata, 16'h0F0E);
    stuck = 1'b0;
    cmd(K_RD, 1, '0);
    chk("err_cleared", bus.err, 0);
    chk("rd1_data", bus.rdata, 16'h07FF);

    // abort a read in CAP
    @(negedge clk);
    bus.req = 1; bus.we = 0; bus.verify = 0; bus.addr = 2'd0;
    @(posedge clk);
    schedule(K_RD, 0, '0);
    @(negedge clk);
    bus.req = 0;
    @(negedge clk);
    chk("abort_cap_sel", bus.mem_sel, 4'b0001);
    #2 clear = 1'b0;
    exp_q.delete();
    held_rd = '0;
    held_err = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_ack", bus.ack, 0);
    chk("abort_sel", bus.mem_sel, 0);
    chk("abort_rdata", bus.rdata, 0);
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    cmd(K_RD, 1, '0);
    chk("post_abort_rd", bus.rdata, 16'h07FF);

    for (int i = 0; i < DEPTH; i++) cmd(K_WR, i, 16'hFFFF);
    cmd(K_IN, 0, '0);
    chk("init_lat", lat, 5);
    for (int i = 0; i < 4; i++) begin
      chk("init_walk", sel_log[i+1], walk[i]);
      chk("init_rw", rw_log[i+1], 1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cmd(K_RD, i, '0);
      chk("init_rd", bus.rdata, 16'h0000);
    end

    // init beats a simultaneous read request; the read follows after the init ack
    @(negedge clk);
    bus.init = 1; bus.req = 1; bus.we = 0; bus.verify = 0; bus.addr = 2'd2; bus.wdata = 16'hAAAA;
    @(posedge clk);
    schedule(K_IN, 0, '0);
    exp_q.push_back(mk(0, 0, '0, 0, '0));
    schedule(K_RD, 2, '0);
    wait_ack();
    chk("prio_init_lat", lat, 5);
    chk("prio_first_sel", sel_log[1], 4'b0001);
    wait_ack();
    chk("prio_rd_lat", lat, 4);
    @(negedge clk);
    bus.req = 0;

    // inputs wiggling while busy must not reach the bank
    @(negedge clk);
    bus.req = 1; bus.we = 1; bus.verify = 0; bus.addr = 2'd0; bus.wdata = 16'h1234;
    @(posedge clk);
    schedule(K_WR, 0, 16'h1234);
    @(negedge clk);
    bus.req = 0; bus.we = 0; bus.verify = 1; bus.addr = 2'd3; bus.wdata = 16'hBEEF;
    chk("ign_din", bus.mem_din, 16'h1234);
    chk("ign_sel", bus.mem_sel, 4'b0001);
    @(negedge clk);
    bus.req = 1;
    chk("ign_ack", bus.ack, 1);
    @(negedge clk);
    bus.req = 0;
    cmd(K_RD, 3, '0);
    chk("ign_rd3", bus.rdata, 16'h0000);
    cmd(K_RD, 0, '0);
    chk("ign_rd0", bus.rdata, 16'h1234);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
